// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with show-ahead (first-word-fall-through) read data,
//   occupancy count, programmable almost-full / almost-empty thresholds and
//   registered overflow / underflow error pulses.
//
// Parameters
//   DATA_W   : data width in bits (>= 1)
//   DEPTH    : entry count, power of two (>= 2)
//   AF_LEVEL : almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL : almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   i_clock          : sole clock, rising edge
//   i_reset          : synchronous active-high reset
//   i_clear          : synchronous flush, lower priority than reset
//   i_data_in        : write data, sampled on an accepted write
//   i_write          : write request
//   i_read           : read request, pops the head entry
//   o_data_out       : head entry, 0 when empty
//   o_full           : count == DEPTH
//   o_empty          : count == 0
//   o_almost_full    : count >= AF_LEVEL
//   o_almost_empty   : count <= AE_LEVEL
//   o_count          : occupancy 0..DEPTH
//   o_overflow       : write rejected on the previous edge
//   o_underflow      : read rejected on the previous edge
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic [DATA_W-1:0]          i_data_in,
  input  logic                       i_write,
  input  logic                       i_read,
  output logic [DATA_W-1:0]          o_data_out,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  // Storage is deliberately not reset; only control state is.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_flush;

  assign w_full  = (r_count == FULL_C);
  assign w_empty = (r_count == '0);
  assign w_flush = i_reset | i_clear;

  // A write while full is legal only when the head is being popped in the
  // same cycle: the freed slot is exactly the one wr_ptr points at.
  assign w_rd_acc = i_read  & ~w_empty;
  assign w_wr_acc = i_write & (~w_full | i_read);

  // Data path: no reset, gated off during reset/clear so flushes leave
  // memory untouched.
  always_ff @(posedge i_clock) begin
    if (w_wr_acc && !w_flush) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // Control state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clear) begin
      // Requests in a clear cycle are dropped without raising errors.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= i_write & ~w_wr_acc;
      r_underflow <= i_read  & ~w_rd_acc;
    end
  end

  // Outputs decode registered state only.
  assign o_data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= AF_C);
  assign o_almost_empty = (r_count <= AE_C);
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
